alu_muldiv_seq: RTL and testbench

- Iterative 16-bit unsigned multiply/divide sequencer for the risc16 execute stage.
- Drives the shared combinational ALU as its initiator: it issues alu_func/a/b each cycle and captures the ALU's same-cycle result, so no adder or subtractor is duplicated.
- Faces the CPU through a start/ready request handshake and a result_valid/result_ready response handshake.
- While busy it owns the ALU via alu_own; the execute-stage operand mux selects this block's ALU inputs when alu_own=1.

---
 rtl/alu_muldiv_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Iterative 16-bit unsigned MUL/DIVU sequencer that borrows the shared execute-stage ALU.
// One ALU operation per cycle; the operands for the next cycle are precomputed so every output is a flop.
package alu_muldiv_seq_pkg;
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_func_e;
endpackage

module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int unsigned ITER = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [15:0]       opa,
    input  logic [15:0]       opb,
    output logic              ready,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [15:0]       result_lo,
    output logic [15:0]       result_hi,
    output logic              div_by_zero,
    output logic              alu_own,
    output alu_func_e         alu_func,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    input  logic [15:0]       alu_out
);

    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = $clog2(ITER);
    localparam logic        OP_DIVU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [W-1:0]     dvd_q, dvd_d;
    logic [W-1:0]     divisor_q, divisor_d;

    logic             ready_q, ready_d;
    logic             result_valid_q, result_valid_d;
    logic [W-1:0]     result_lo_q, result_lo_d;
    logic [W-1:0]     result_hi_q, result_hi_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             alu_own_q, alu_own_d;
    alu_func_e        alu_func_q, alu_func_d;
    logic [W-1:0]     alu_a_q, alu_a_d;
    logic [W-1:0]     alu_b_q, alu_b_d;

    // Restoring-division step: 17-bit partial remainder against the divisor
    logic [W:0]       div_s;
    logic             div_ge;
    logic [W-1:0]     div_rem_next;
    logic             last_iter;

    assign div_s        = {rem_q, dvd_q[W-1]};
    assign div_ge       = (div_s >= {1'b0, divisor_q});
    assign div_rem_next = div_ge ? alu_out : div_s[W-1:0];
    assign last_iter    = (cnt_q == CNT_W'(ITER - 1));

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        rem_d          = rem_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        dvd_d          = dvd_q;
        divisor_d      = divisor_q;
        ready_d        = ready_q;
        result_valid_d = result_valid_q;
        result_lo_d    = result_lo_q;
        result_hi_d    = result_hi_q;
        div_by_zero_d  = div_by_zero_q;
        alu_own_d      = 1'b0;
        alu_func_d     = ALU_ADD;
        alu_a_d        = '0;
        alu_b_d        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    cnt_d     = '0;
                    acc_d     = '0;
                    rem_d     = '0;
                    mcand_d   = opa;
                    mplier_d  = opb;
                    dvd_d     = opa;
                    divisor_d = opb;
                    ready_d   = 1'b0;
                    if (op == OP_DIVU && opb == '0) begin
                        state_d        = DONE;
                        result_valid_d = 1'b1;
                        result_lo_d    = '1;
                        result_hi_d    = opa;
                        div_by_zero_d  = 1'b1;
                    end else begin
                        // Preload operands for iteration 0
                        state_d   = RUN;
                        alu_own_d = 1'b1;
                        if (op == OP_DIVU) begin
                            alu_func_d = ALU_SUB;
                            alu_a_d    = {{(W-1){1'b0}}, opa[W-1]};
                            alu_b_d    = opb;
                        end else begin
                            alu_func_d = ALU_ADD;
                            alu_a_d    = '0;
                            alu_b_d    = opb[0] ? opa : '0;
                        end
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == OP_DIVU) begin
                    rem_d = div_rem_next;
                    acc_d = {acc_q[W-2:0], div_ge};
                    dvd_d = dvd_q << 1;
                end else begin
                    acc_d    = alu_out;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (last_iter) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    div_by_zero_d  = 1'b0;
                    if (op_q == OP_DIVU) begin
                        result_lo_d = {acc_q[W-2:0], div_ge};
                        result_hi_d = div_rem_next;
                    end else begin
                        result_lo_d = alu_out;
                        result_hi_d = '0;
                    end
                end else begin
                    // Operands for the following iteration
                    alu_own_d = 1'b1;
                    if (op_q == OP_DIVU) begin
                        alu_func_d = ALU_SUB;
                        alu_a_d    = {div_rem_next[W-2:0], dvd_q[W-2]};
                        alu_b_d    = divisor_q;
                    end else begin
                        alu_func_d = ALU_ADD;
                        alu_a_d    = alu_out;
                        alu_b_d    = mplier_q[1] ? (mcand_q << 1) : '0;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d        = IDLE;
                    ready_d        = 1'b1;
                    result_valid_d = 1'b0;
                end
            end
            default: begin
                state_d        = IDLE;
                ready_d        = 1'b1;
                result_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= 1'b0;
            cnt_q          <= '0;
            acc_q          <= '0;
            rem_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            dvd_q          <= '0;
            divisor_q      <= '0;
            ready_q        <= 1'b1;
            result_valid_q <= 1'b0;
            result_lo_q    <= '0;
            result_hi_q    <= '0;
            div_by_zero_q  <= 1'b0;
            alu_own_q      <= 1'b0;
            alu_func_q     <= ALU_ADD;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            rem_q          <= rem_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            dvd_q          <= dvd_d;
            divisor_q      <= divisor_d;
            ready_q        <= ready_d;
            result_valid_q <= result_valid_d;
            result_lo_q    <= result_lo_d;
            result_hi_q    <= result_hi_d;
            div_by_zero_q  <= div_by_zero_d;
            alu_own_q      <= alu_own_d;
            alu_func_q     <= alu_func_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
        end
    end

    assign ready        = ready_q;
    assign result_valid = result_valid_q;
    assign result_lo    = result_lo_q;
    assign result_hi    = result_hi_q;
    assign div_by_zero  = div_by_zero_q;
    assign alu_own      = alu_own_q;
    assign alu_func     = alu_func_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural shared ALU.
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        ready;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic        div_by_zero;
    logic        alu_own;
    alu_func_e   alu_func;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;

    int tests_run;
    int tests_failed;

    alu_muldiv_seq #(.ITER(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .opa          (opa),
        .opb          (opb),
        .ready        (ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .div_by_zero  (div_by_zero),
        .alu_own      (alu_own),
        .alu_func     (alu_func),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out)
    );

    // Shared execute-stage ALU stand-in
    always_comb begin
        case (alu_func)
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            default: alu_out = alu_a + alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for result_valid, check latency/results, then accept it
    task automatic run_op(input string tag, input logic o, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_lo, input logic [15:0] exp_hi, input logic exp_dz,
                          input int exp_lat, input int exp_own);
        int n;
        int own_cnt;
        check({tag, " ready_before"}, 32'(ready), 32'd1);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        step();
        start   = 1'b0;
        n       = 1;
        own_cnt = 0;
        while (!result_valid && n < 40) begin
            if (alu_own) own_cnt++;
            step();
            n++;
        end
        if (alu_own) own_cnt++;
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " alu_own_cycles"}, 32'(own_cnt), 32'(exp_own));
        check({tag, " result_lo"}, 32'(result_lo), 32'(exp_lo));
        check({tag, " result_hi"}, 32'(result_hi), 32'(exp_hi));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dz));
        check({tag, " ready_in_done"}, 32'(ready), 32'd0);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, " ready_after"}, 32'(ready), 32'd1);
        check({tag, " valid_after"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        int n;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        op           = 1'b0;
        opa          = '0;
        opb          = '0;
        result_ready = 1'b0;
        repeat (2) step();

        check("rst ready", 32'(ready), 32'd1);
        check("rst valid", 32'(result_valid), 32'd0);
        check("rst lo", 32'(result_lo), 32'd0);
        check("rst hi", 32'(result_hi), 32'd0);
        check("rst dz", 32'(div_by_zero), 32'd0);
        check("rst own", 32'(alu_own), 32'd0);
        check("rst func", 32'(alu_func), 32'(ALU_ADD));
        check("rst alu_a", 32'(alu_a), 32'd0);
        check("rst alu_b", 32'(alu_b), 32'd0);
        rst_n = 1'b1;
        step();

        run_op("mul 3x5",       1'b0, 16'd3,    16'd5,    16'h000F, 16'h0000, 1'b0, 17, 16);
        run_op("mul ffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17, 16);
        run_op("mul 1234x0",    1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 17, 16);
        run_op("divu 100/7",    1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17, 16);
        run_op("divu ffff/8001",1'b1, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 17, 16);
        run_op("divu 5a5a/0",   1'b1, 16'h5A5A, 16'h0000, 16'hFFFF, 16'h5A5A, 1'b1, 1,  0);
        run_op("divu ffff/1",   1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, 16);

        // Backpressure with start held high throughout RUN and DONE
        start = 1'b1;
        op    = 1'b0;
        opa   = 16'd7;
        opb   = 16'd9;
        step();
        opa = 16'd1;
        opb = 16'd1;
        n   = 1;
        while (!result_valid && n < 40) begin
            step();
            n++;
        end
        check("bp latency", 32'(n), 32'd17);
        for (int i = 0; i < 10; i++) begin
            check("bp valid", 32'(result_valid), 32'd1);
            check("bp ready", 32'(ready), 32'd0);
            check("bp lo", 32'(result_lo), 32'd63);
            check("bp hi", 32'(result_hi), 32'd0);
            step();
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        start        = 1'b0;
        check("accept+start ready", 32'(ready), 32'd1);
        check("accept+start valid", 32'(result_valid), 32'd0);
        check("accept+start own", 32'(alu_own), 32'd0);
        run_op("mul 2x3 after", 1'b0, 16'd2, 16'd3, 16'd6, 16'd0, 1'b0, 17, 16);

        // Reset during RUN cycle 8 abandons the operation
        start = 1'b1;
        op    = 1'b0;
        opa   = 16'hFFFF;
        opb   = 16'd3;
        step();
        start = 1'b0;
        repeat (7) step();
        check("mid own before rst", 32'(alu_own), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst ready", 32'(ready), 32'd1);
        check("mid rst valid", 32'(result_valid), 32'd0);
        check("mid rst own", 32'(alu_own), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post rst valid", 32'(result_valid), 32'd0);
        run_op("mul 2x2 post rst", 1'b0, 16'd2, 16'd2, 16'd4, 16'd0, 1'b0, 17, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
